// File: rtl/stage_exe_mc.sv
// Execute stage: single-cycle ALU with forwarding and branch-target generation, plus an
// iterative MUL/DIVU/REMU unit that holds the front end via busy until its result registers.
module stage_exe_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             isJumped,
    input  logic             nop_id,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_imm,
    input  logic [WIDTH-1:0] npc,
    input  logic [3:0]       control_oper,
    input  logic             control_use_b,
    input  logic             control_Reg_DST,
    input  logic             control_mc,
    input  logic [1:0]       control_mc_op,
    input  logic [1:0]       for_a,
    input  logic [1:0]       for_b,
    input  logic [WIDTH-1:0] result_from_exe,
    input  logic [WIDTH-1:0] result_from_mem,
    input  logic             control_is_jump,
    input  logic             control_branch_eq,
    input  logic             control_branch_inc,
    input  logic [1:0]       wbi,
    input  logic             M,
    input  logic [REG_W-1:0] regaddr1,
    input  logic [REG_W-1:0] regaddr2,
    output logic             busy,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] jump_address,
    output logic             is_jump_o,
    output logic             branch_eq_o,
    output logic             branch_inc_o,
    output logic [1:0]       wbi_o,
    output logic             M_o,
    output logic [REG_W-1:0] regaddr_o,
    output logic [REG_W-1:0] rt_id,
    output logic [WIDTH-1:0] data_b_o,
    output logic             nop
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OpFunct = 4'd0, OpAdd = 4'd1, OpSub = 4'd2, OpAnd = 4'd3,
                           OpOr = 4'd4, OpXor = 4'd5, OpSlt = 4'd6, OpSltu = 4'd7,
                           OpLui = 4'd8, OpNor = 4'd9, OpSll = 4'd10, OpSrl = 4'd11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [3:0]       op_eff;
    logic [4:0]       shamt;
    logic             mc_valid, ld_alu, ld_mc, accept;

    // Iterative unit: acc holds product or partial remainder, opa multiplier or quotient,
    // opb shifting multiplicand or fixed divisor.
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [1:0]       mc_op_q;
    logic [1:0]       wbi_q;
    logic             m_q;
    logic [REG_W-1:0] dst_q, rt_q;
    logic [WIDTH-1:0] jaddr_q, b_q, mc_result;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             rem_ge, is_div;

    logic [WIDTH-1:0] out_d, jaddr_d, data_b_d;
    logic             zero_d, is_jump_d, beq_d, binc_d, m_d, nop_d;
    logic [1:0]       wbi_d;
    logic [REG_W-1:0] regaddr_d, rt_d;

    always_comb begin
        fwd_a = (for_a == 2'b01) ? result_from_exe : (for_a == 2'b10) ? result_from_mem : data_a;
        fwd_b = (for_b == 2'b01) ? result_from_exe : (for_b == 2'b10) ? result_from_mem : data_b;
        alu_b = control_use_b ? data_imm : fwd_b;
        shamt = data_imm[10:6];
    end

    always_comb begin
        op_eff = control_oper;
        if (control_oper == OpFunct) begin
            case (data_imm[5:0])
                6'h20, 6'h21: op_eff = OpAdd;
                6'h22, 6'h23: op_eff = OpSub;
                6'h24:        op_eff = OpAnd;
                6'h25:        op_eff = OpOr;
                6'h26:        op_eff = OpXor;
                6'h27:        op_eff = OpNor;
                6'h2a:        op_eff = OpSlt;
                6'h2b:        op_eff = OpSltu;
                6'h00:        op_eff = OpSll;
                6'h02:        op_eff = OpSrl;
                default:      op_eff = OpAdd;
            endcase
        end
        case (op_eff)
            OpAdd:   alu_res = fwd_a + alu_b;
            OpSub:   alu_res = fwd_a - alu_b;
            OpAnd:   alu_res = fwd_a & alu_b;
            OpOr:    alu_res = fwd_a | alu_b;
            OpXor:   alu_res = fwd_a ^ alu_b;
            OpNor:   alu_res = ~(fwd_a | alu_b);
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, fwd_a < alu_b};
            OpLui:   alu_res = alu_b << 16;
            OpSll:   alu_res = alu_b << shamt;
            OpSrl:   alu_res = alu_b >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign mc_valid = control_mc & ~nop_id;
    assign busy = reset & ((state_q == StRun) | ((state_q == StIdle) & mc_valid) |
                           ((state_q == StDone) & stall));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_alu  = 1'b0;
        ld_mc   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mc_valid) begin
                    if (!stall && !isJumped) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end else if (!stall && !isJumped) begin
                    ld_alu = 1'b1;
                end
            end
            StRun: begin
                if (isJumped) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
                end
            end
            StDone: begin
                if (isJumped) begin
                    state_d = StIdle;
                end else if (!stall) begin
                    ld_mc   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Restoring divide step: bit WIDTH of the difference is the borrow.
    always_comb begin
        is_div   = (mc_op_q == 2'b01) | (mc_op_q == 2'b10);
        rem_sh   = {acc_q, opa_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        rem_ge   = ~rem_diff[WIDTH];
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        if (accept) begin
            acc_d = '0;
            opa_d = fwd_a;
            opb_d = fwd_b;
        end else if (state_q == StRun) begin
            if (is_div) begin
                acc_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], rem_ge};
            end else begin
                acc_d = opa_q[0] ? acc_q + opb_q : acc_q;
                opa_d = opa_q >> 1;
                opb_d = opb_q << 1;
            end
        end
        mc_result = (mc_op_q == 2'b01) ? opa_q : acc_q;
    end

    always_comb begin
        out_d     = '0;
        jaddr_d   = '0;
        is_jump_d = 1'b0;
        beq_d     = 1'b0;
        binc_d    = 1'b0;
        wbi_d     = '0;
        m_d       = 1'b0;
        regaddr_d = '0;
        rt_d      = '0;
        data_b_d  = '0;
        nop_d     = 1'b1;
        if (ld_alu) begin
            out_d     = alu_res;
            jaddr_d   = npc + data_imm;
            is_jump_d = control_is_jump;
            beq_d     = control_branch_eq;
            binc_d    = control_branch_inc;
            wbi_d     = wbi;
            m_d       = M;
            regaddr_d = control_Reg_DST ? regaddr1 : regaddr2;
            rt_d      = regaddr2;
            data_b_d  = fwd_b;
            nop_d     = nop_id;
        end else if (ld_mc) begin
            out_d     = mc_result;
            jaddr_d   = jaddr_q;
            wbi_d     = wbi_q;
            m_d       = m_q;
            regaddr_d = dst_q;
            rt_d      = rt_q;
            data_b_d  = b_q;
            nop_d     = 1'b0;
        end
        zero_d = (ld_alu | ld_mc) & (out_d == '0);
    end

    always_ff @(posedge clock) begin
        acc_q <= acc_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
        if (accept) begin
            mc_op_q <= control_mc_op;
            wbi_q   <= wbi;
            m_q     <= M;
            dst_q   <= control_Reg_DST ? regaddr1 : regaddr2;
            rt_q    <= regaddr2;
            jaddr_q <= npc + data_imm;
            b_q     <= fwd_b;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            out          <= '0;
            zero         <= 1'b0;
            jump_address <= '0;
            is_jump_o    <= 1'b0;
            branch_eq_o  <= 1'b0;
            branch_inc_o <= 1'b0;
            wbi_o        <= '0;
            M_o          <= 1'b0;
            regaddr_o    <= '0;
            rt_id        <= '0;
            data_b_o     <= '0;
            nop          <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out          <= out_d;
            zero         <= zero_d;
            jump_address <= jaddr_d;
            is_jump_o    <= is_jump_d;
            branch_eq_o  <= beq_d;
            branch_inc_o <= binc_d;
            wbi_o        <= wbi_d;
            M_o          <= m_d;
            regaddr_o    <= regaddr_d;
            rt_id        <= rt_d;
            data_b_o     <= data_b_d;
            nop          <= nop_d;
        end
    end

endmodule

// File: tb/tb_stage_exe_mc.sv
// Directed bench for stage_exe_mc: a 32-bit instance for ALU and multi-cycle flows and a
// 16-bit instance for the narrow multiply wrap-around case.
module tb_stage_exe_mc;

    logic        clock, reset, stall, isJumped, nop_id;
    logic [31:0] data_a, data_b, data_imm, npc, result_from_exe, result_from_mem;
    logic [3:0]  control_oper;
    logic        control_use_b, control_Reg_DST, control_mc, control_mc16;
    logic [1:0]  control_mc_op, for_a, for_b, wbi;
    logic        control_is_jump, control_branch_eq, control_branch_inc, M;
    logic [4:0]  regaddr1, regaddr2;

    logic        busy, zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, nop;
    logic [31:0] out, jump_address, data_b_o;
    logic [1:0]  wbi_o;
    logic [4:0]  regaddr_o, rt_id;

    logic        busy16, zero16, is_jump16, beq16, binc16, m16, nop16;
    logic [15:0] out16, jaddr16, data_b16;
    logic [1:0]  wbi16;
    logic [4:0]  regaddr16, rt16;

    int n_checks = 0;
    int n_errors = 0;

    stage_exe_mc #(.WIDTH(32), .REG_W(5)) u_dut (
        .clock(clock), .reset(reset), .stall(stall), .isJumped(isJumped), .nop_id(nop_id),
        .data_a(data_a), .data_b(data_b), .data_imm(data_imm), .npc(npc),
        .control_oper(control_oper), .control_use_b(control_use_b),
        .control_Reg_DST(control_Reg_DST), .control_mc(control_mc),
        .control_mc_op(control_mc_op), .for_a(for_a), .for_b(for_b),
        .result_from_exe(result_from_exe), .result_from_mem(result_from_mem),
        .control_is_jump(control_is_jump), .control_branch_eq(control_branch_eq),
        .control_branch_inc(control_branch_inc), .wbi(wbi), .M(M),
        .regaddr1(regaddr1), .regaddr2(regaddr2), .busy(busy), .out(out), .zero(zero),
        .jump_address(jump_address), .is_jump_o(is_jump_o), .branch_eq_o(branch_eq_o),
        .branch_inc_o(branch_inc_o), .wbi_o(wbi_o), .M_o(M_o), .regaddr_o(regaddr_o),
        .rt_id(rt_id), .data_b_o(data_b_o), .nop(nop)
    );

    stage_exe_mc #(.WIDTH(16), .REG_W(5)) u_dut16 (
        .clock(clock), .reset(reset), .stall(stall), .isJumped(isJumped), .nop_id(nop_id),
        .data_a(data_a[15:0]), .data_b(data_b[15:0]), .data_imm(data_imm[15:0]),
        .npc(npc[15:0]), .control_oper(control_oper), .control_use_b(control_use_b),
        .control_Reg_DST(control_Reg_DST), .control_mc(control_mc16),
        .control_mc_op(control_mc_op), .for_a(for_a), .for_b(for_b),
        .result_from_exe(result_from_exe[15:0]), .result_from_mem(result_from_mem[15:0]),
        .control_is_jump(control_is_jump), .control_branch_eq(control_branch_eq),
        .control_branch_inc(control_branch_inc), .wbi(wbi), .M(M),
        .regaddr1(regaddr1), .regaddr2(regaddr2), .busy(busy16), .out(out16), .zero(zero16),
        .jump_address(jaddr16), .is_jump_o(is_jump16), .branch_eq_o(beq16),
        .branch_inc_o(binc16), .wbi_o(wbi16), .M_o(m16), .regaddr_o(regaddr16),
        .rt_id(rt16), .data_b_o(data_b16), .nop(nop16)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles from the current (pre-acceptance) cycle up to the DONE cycle.
    task automatic count_busy(input bit w16, output int n, output int nop_bad);
        logic b, nb;
        n = 0;
        nop_bad = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            b  = w16 ? busy16 : busy;
            nb = w16 ? nop16 : nop;
            if (!b) break;
            if (k > 0 && nb !== 1'b1) nop_bad++;
            n++;
            tick();
        end
    endtask

    task automatic setup_mc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        data_a = a; data_b = b; for_a = 2'b00; for_b = 2'b00;
        control_mc_op = op; control_use_b = 1'b0; nop_id = 1'b0;
        wbi = 2'b11; M = 1'b0; control_Reg_DST = 1'b1; regaddr1 = 5'd5; regaddr2 = 5'd6;
    endtask

    task automatic run_mc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int n, nb;
        setup_mc(op, a, b);
        control_mc = 1'b1;
        count_busy(1'b0, n, nb);
        check({tag, "_busy_cycles"}, n, 33);
        check({tag, "_nop_while_busy"}, nb, 0);
        tick();
        control_mc = 1'b0;
        check({tag, "_out"}, out, exp);
        check({tag, "_nop"}, {31'b0, nop}, 0);
        check({tag, "_wbi"}, {30'b0, wbi_o}, 32'd3);
        check({tag, "_regaddr"}, {27'b0, regaddr_o}, 32'd5);
    endtask

    initial begin
        int n, nb;
        logic wbi_nz;

        // Reset with random inputs
        reset = 1'b0;
        {stall, isJumped, nop_id, control_use_b, control_Reg_DST} = 5'($urandom);
        {control_mc, control_is_jump, control_branch_eq, control_branch_inc, M} = 5'($urandom);
        control_mc16 = 1'b1;
        data_a = $urandom; data_b = $urandom; data_imm = $urandom; npc = $urandom;
        result_from_exe = $urandom; result_from_mem = $urandom;
        control_oper = 4'($urandom); control_mc_op = 2'($urandom);
        for_a = 2'($urandom); for_b = 2'($urandom); wbi = 2'($urandom);
        regaddr1 = 5'($urandom); regaddr2 = 5'($urandom);
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_regaddr", {27'b0, regaddr_o}, 0);
        check("rst_wbi", {30'b0, wbi_o}, 0);
        check("rst_nop", {31'b0, nop}, 1);
        check("rst_busy", {31'b0, busy}, 0);

        stall = 0; isJumped = 0; nop_id = 0; control_mc = 0; control_mc16 = 0;
        control_is_jump = 0; control_branch_eq = 0; control_branch_inc = 0;
        reset = 1'b1;

        // ALU add with forwarded A and immediate B
        for_a = 2'b01; for_b = 2'b00; result_from_exe = 5; data_imm = 7; data_a = 0;
        control_use_b = 1; control_Reg_DST = 0; regaddr2 = 9; regaddr1 = 3;
        control_oper = 4'd1; npc = 32'h100; wbi = 2'b10; M = 1;
        tick();
        check("add_out", out, 12);
        check("add_regaddr", {27'b0, regaddr_o}, 9);
        check("add_nop", {31'b0, nop}, 0);
        check("add_jaddr", jump_address, 32'h107);
        check("add_wbi", {30'b0, wbi_o}, 2);
        check("add_zero", {31'b0, zero}, 0);

        stall = 1;
        tick();
        check("stall_out", out, 0);
        check("stall_nop", {31'b0, nop}, 1);
        check("stall_wbi", {30'b0, wbi_o}, 0);
        stall = 0;

        // SUB with mem-forwarded B giving zero
        control_oper = 4'd2; for_a = 2'b00; data_a = 10; for_b = 2'b10;
        result_from_mem = 10; result_from_exe = 99; control_use_b = 0;
        tick();
        check("sub_out", out, 0);
        check("sub_zero", {31'b0, zero}, 1);
        check("sub_data_b", data_b_o, 10);

        // data_b_o carries forwarded B even when the immediate feeds the ALU
        control_oper = 4'd1; for_b = 2'b01; control_use_b = 1; data_imm = 7;
        tick();
        check("imm_out", out, 17);
        check("imm_data_b", data_b_o, 99);

        // Multi-cycle ops on the 32-bit instance
        run_mc(2'b00, 7, 6, 42, "mul");
        run_mc(2'b01, 100, 7, 14, "divu");
        run_mc(2'b10, 100, 7, 2, "remu");
        run_mc(2'b01, 100, 0, 32'hFFFF_FFFF, "divu0");
        run_mc(2'b10, 100, 0, 100, "remu0");
        run_mc(2'b11, 32'h10001, 32'h10001, 32'h0002_0001, "mul11");

        // 16-bit multiply wraps modulo 2^16
        setup_mc(2'b00, 32'hFFFF, 32'hFFFF);
        control_mc16 = 1'b1;
        count_busy(1'b1, n, nb);
        check("mul16_busy_cycles", n, 17);
        tick();
        control_mc16 = 1'b0;
        check("mul16_out", {16'b0, out16}, 32'h0001);
        check("mul16_nop", {31'b0, nop16}, 0);

        // Abort on the 10th RUN cycle
        setup_mc(2'b00, 7, 6);
        control_mc = 1'b1;
        wbi_nz = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            wbi_nz |= (wbi_o != 2'b00);
            tick();
        end
        isJumped = 1'b1;
        #1;
        check("abort_busy_before", {31'b0, busy}, 1);
        tick();
        isJumped = 1'b0; control_mc = 1'b0; wbi = 2'b00;
        check("abort_nop", {31'b0, nop}, 1);
        #1;
        check("abort_busy_after", {31'b0, busy}, 0);
        for (int i = 0; i < 40; i++) begin
            wbi_nz |= (wbi_o != 2'b00);
            tick();
        end
        check("abort_no_writeback", {31'b0, wbi_nz}, 0);

        // Stall held three cycles in DONE
        setup_mc(2'b00, 3, 4);
        control_mc = 1'b1;
        count_busy(1'b0, n, nb);
        check("dstall_busy_cycles", n, 33);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("dstall_busy", {31'b0, busy}, 1);
            tick();
            check("dstall_nop", {31'b0, nop}, 1);
            check("dstall_out", out, 0);
        end
        stall = 1'b0;
        #1;
        check("dstall_busy_release", {31'b0, busy}, 0);
        tick();
        control_mc = 1'b0;
        check("dstall_out_final", out, 12);
        check("dstall_nop_final", {31'b0, nop}, 0);
        #1;
        check("dstall_busy_idle", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
